// File: rtl/gain_slew_if.sv
// gain_slew_if: bundles the pot targets, mute request and slewed gain
// outputs exchanged between the pot interface, the slew limiter and the
// equalizer engine.
interface gain_slew_if;
  logic [11:0] pot_lp;
  logic [11:0] pot_b1;
  logic [11:0] pot_b2;
  logic [11:0] pot_b3;
  logic [11:0] pot_hp;
  logic [11:0] pot_vol;
  logic        mute;
  logic [11:0] LP_gain;
  logic [11:0] B1_gain;
  logic [11:0] B2_gain;
  logic [11:0] B3_gain;
  logic [11:0] HP_gain;
  logic [11:0] volume;
  logic        steady;
  logic        sweep_done;

  // Side that supplies targets and consumes the smoothed gains.
  modport master (
    output pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol, mute,
    input  LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, volume,
    input  steady, sweep_done
  );

  // The slew limiter itself.
  modport slave (
    input  pot_lp, pot_b1, pot_b2, pot_b3, pot_hp, pot_vol, mute,
    output LP_gain, B1_gain, B2_gain, B3_gain, HP_gain, volume,
    output steady, sweep_done
  );
endinterface

// File: rtl/gain_slew.sv
// gain_slew: slew-rate limiter for five band gains and the volume.
// Every TICK_DIV cycles one sweep walks the six channels (LP, B1, B2, B3,
// HP, VOL), one per cycle, moving each output toward its target by at most
// STEP and landing exactly once within STEP. Volume resets to 0, which gives
// the power-up fade-in. 'steady' reports a sweep in which nothing moved.
// Optional feature macro: GAIN_SLEW_MUTE_EN (mute drives volume target to 0).
module gain_slew #(
  parameter int STEP     = 8,
  parameter int TICK_DIV = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  gain_slew_if.slave  bus
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic signed [12:0] STEP_S     = 13'(STEP);
  localparam logic [11:0]        STEP_U     = 12'(STEP);
  localparam logic [2:0]         CH_LAST    = 3'd5;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_ch;
  logic [2:0]  w_ch_next;
  logic [PW-1:0] r_presc;
  logic        w_tick;
  logic        w_sweep_start;
  logic        w_sweep_end;

  logic [11:0] r_gain [6];
  logic [11:0] w_tgt;
  logic [11:0] w_cur;
  logic [11:0] w_vol_tgt;
  logic [11:0] w_new;
  logic signed [12:0] w_diff;
  logic        w_moved;

  logic        r_changed;
  logic        r_steady;
  logic        r_sweep_done;

`ifdef GAIN_SLEW_MUTE_EN
  assign w_vol_tgt = bus.mute ? 12'h000 : bus.pot_vol;
`else
  // mute is accepted on the port but has no effect in this build.
  logic w_mute_unused;
  assign w_mute_unused = bus.mute;
  assign w_vol_tgt     = bus.pot_vol;
`endif

  assign w_tick = (r_presc == PRESC_LAST);

  // Free-running prescaler that paces the sweeps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // FSM state and channel index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
    end
  end

  // Next-state logic: a tick starts a sweep, channel 5 ends it.
  always_comb begin
    w_state_next  = r_state;
    w_ch_next     = r_ch;
    w_sweep_start = 1'b0;
    w_sweep_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_next  = S_SWEEP;
          w_ch_next     = 3'd0;
          w_sweep_start = 1'b1;
        end
      end
      S_SWEEP: begin
        if (r_ch == CH_LAST) begin
          w_state_next = S_IDLE;
          w_ch_next    = 3'd0;
          w_sweep_end  = 1'b1;
        end else begin
          w_ch_next = r_ch + 3'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_ch_next    = 3'd0;
      end
    endcase
  end

  // Select the target and current value of the channel being processed.
  always_comb begin
    w_tgt = 12'h000;
    w_cur = 12'h000;
    case (r_ch)
      3'd0: begin w_tgt = bus.pot_lp; w_cur = r_gain[0]; end
      3'd1: begin w_tgt = bus.pot_b1; w_cur = r_gain[1]; end
      3'd2: begin w_tgt = bus.pot_b2; w_cur = r_gain[2]; end
      3'd3: begin w_tgt = bus.pot_b3; w_cur = r_gain[3]; end
      3'd4: begin w_tgt = bus.pot_hp; w_cur = r_gain[4]; end
      3'd5: begin w_tgt = w_vol_tgt;  w_cur = r_gain[5]; end
      default: begin w_tgt = 12'h000; w_cur = 12'h000; end
    endcase
  end

  // Step limiter: the 13-bit signed difference cannot wrap, and a step is
  // only taken when the target lies beyond it, so results stay in 0..4095.
  always_comb begin
    w_diff  = $signed({1'b0, w_tgt}) - $signed({1'b0, w_cur});
    w_moved = (w_tgt != w_cur);
    if (w_diff > STEP_S) begin
      w_new = w_cur + STEP_U;
    end else if (w_diff < -STEP_S) begin
      w_new = w_cur - STEP_U;
    end else begin
      w_new = w_tgt;
    end
  end

  // Gain registers: only the channel addressed in this sweep cycle updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        r_gain[i] <= 12'h800;
      end
      r_gain[5] <= 12'h000;
    end else if (r_state == S_SWEEP) begin
      for (int i = 0; i < 6; i++) begin
        if (r_ch == 3'(i)) begin
          r_gain[i] <= w_new;
        end
      end
    end
  end

  // Sticky movement tracking, steady flag and end-of-sweep pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed    <= 1'b0;
      r_steady     <= 1'b0;
      r_sweep_done <= 1'b0;
    end else begin
      r_sweep_done <= w_sweep_end;
      if (w_sweep_start) begin
        r_changed <= 1'b0;
      end else if ((r_state == S_SWEEP) && w_moved) begin
        r_changed <= 1'b1;
      end
      if (w_sweep_end) begin
        r_steady <= ~(r_changed | w_moved);
      end
    end
  end

  assign bus.LP_gain    = r_gain[0];
  assign bus.B1_gain    = r_gain[1];
  assign bus.B2_gain    = r_gain[2];
  assign bus.B3_gain    = r_gain[3];
  assign bus.HP_gain    = r_gain[4];
  assign bus.volume     = r_gain[5];
  assign bus.steady     = r_steady;
  assign bus.sweep_done = r_sweep_done;

endmodule

// File: tb/tb_gain_slew.sv
// tb_gain_slew: directed test of gain_slew with STEP=8, TICK_DIV=16.
module tb_gain_slew;
  localparam int STEP     = 8;
  localparam int TICK_DIV = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  gain_slew_if bus ();

  gain_slew #(.STEP(STEP), .TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return at the negedge where sweep_done is seen high (bounded).
  task automatic wait_sweep_done();
    int n;
    bit found;
    n = 0;
    found = 0;
    while (n < 64 && !found) begin
      @(negedge clk);
      n++;
      if (bus.sweep_done) found = 1;
    end
    if (!found) check("sweep_timeout", 32'd0, 32'd1);
  endtask

  // Count rising edges until sweep_done is high, then align to its negedge.
  task automatic count_to_done(output int n);
    bit found;
    n = 0;
    found = 0;
    while (n < 64 && !found) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.sweep_done) found = 1;
    end
    @(negedge clk);
  endtask

  // Called right after wait_sweep_done; lands 1 time unit into the cycle
  // in which channel k of the next sweep is processed.
  task automatic sync_ch(input int k);
    repeat (10 + k) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_lp"},     32'(bus.LP_gain), 32'h800);
    check({tag, "_b1"},     32'(bus.B1_gain), 32'h800);
    check({tag, "_b2"},     32'(bus.B2_gain), 32'h800);
    check({tag, "_b3"},     32'(bus.B3_gain), 32'h800);
    check({tag, "_hp"},     32'(bus.HP_gain), 32'h800);
    check({tag, "_vol"},    32'(bus.volume),  32'h000);
    check({tag, "_steady"}, 32'(bus.steady),  32'h0);
    check({tag, "_done"},   32'(bus.sweep_done), 32'h0);
  endtask

  initial begin
    int n;
    logic [11:0] exp;

    bus.pot_lp  = 12'h800;
    bus.pot_b1  = 12'h800;
    bus.pot_b2  = 12'h800;
    bus.pot_b3  = 12'h800;
    bus.pot_hp  = 12'h800;
    bus.pot_vol = 12'h000;
    bus.mute    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    count_to_done(n);
    check("first_done_latency", 32'(n), 32'(TICK_DIV + 6));
    check("reset_steady", 32'(bus.steady), 32'h1);
    $display("reset: first sweep_done after %0d cycles, steady=%0b", n, bus.steady);

    // Volume ramp 0 -> 8 -> 16 -> 20
    bus.pot_vol = 12'h014;
    wait_sweep_done();
    check("ramp_vol_s1", 32'(bus.volume), 32'h008);
    check("ramp_steady_s1", 32'(bus.steady), 32'h0);
    wait_sweep_done();
    check("ramp_vol_s2", 32'(bus.volume), 32'h010);
    check("ramp_steady_s2", 32'(bus.steady), 32'h0);
    wait_sweep_done();
    check("ramp_vol_s3", 32'(bus.volume), 32'h014);
    check("ramp_steady_s3", 32'(bus.steady), 32'h0);
    wait_sweep_done();
    check("ramp_vol_s4", 32'(bus.volume), 32'h014);
    check("ramp_steady_s4", 32'(bus.steady), 32'h1);
    check("ramp_lp_untouched", 32'(bus.LP_gain), 32'h800);
    $display("ramp up: volume=%0h steady=%0b", bus.volume, bus.steady);

    // Target change during B2 cycle is seen by B3 in the same sweep
    sync_ch(2);
    bus.pot_b3 = 12'h810;
    wait_sweep_done();
    check("mid_b3_same_sweep", 32'(bus.B3_gain), 32'h808);
    wait_sweep_done();
    check("mid_b3_next_sweep", 32'(bus.B3_gain), 32'h810);
    $display("mid-sweep change: B3_gain=%0h", bus.B3_gain);

    // Target change during VOL cycle is seen by LP only next sweep
    sync_ch(5);
    bus.pot_lp = 12'h808;
    wait_sweep_done();
    check("late_lp_this_sweep", 32'(bus.LP_gain), 32'h800);
    wait_sweep_done();
    check("late_lp_next_sweep", 32'(bus.LP_gain), 32'h808);
    $display("late change: LP_gain=%0h", bus.LP_gain);

    // Drive LP to full scale, then ramp down to 0 with exact landing
    bus.pot_lp = 12'hFFF;
    repeat (260) wait_sweep_done();
    check("lp_full_scale", 32'(bus.LP_gain), 32'hFFF);
    bus.pot_lp = 12'h000;
    exp = 12'hFFF;
    for (int s = 1; s <= 513; s++) begin
      wait_sweep_done();
      exp = (exp > 12'd8) ? exp - 12'd8 : 12'h000;
      check("lp_ramp_down", 32'(bus.LP_gain), 32'(exp));
    end
    check("lp_landed_zero", 32'(bus.LP_gain), 32'h000);
    $display("ramp down: LP_gain=%0h after 513 sweeps", bus.LP_gain);

    // Mute behaviour from a steady volume of 0x040
    bus.pot_vol = 12'h040;
    repeat (8) wait_sweep_done();
    check("mute_pre_vol", 32'(bus.volume), 32'h040);
    check("mute_pre_steady", 32'(bus.steady), 32'h1);
    bus.mute = 1'b1;
    exp = 12'h040;
    for (int s = 1; s <= 8; s++) begin
      wait_sweep_done();
`ifdef GAIN_SLEW_MUTE_EN
      exp = exp - 12'd8;
`endif
      check("mute_ramp", 32'(bus.volume), 32'(exp));
    end
    $display("mute asserted: volume=%0h", bus.volume);
    bus.mute = 1'b0;
    repeat (8) wait_sweep_done();
    check("unmute_vol", 32'(bus.volume), 32'h040);
    $display("mute released: volume=%0h", bus.volume);

    // Reset pulse during ch=3
    sync_ch(3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    count_to_done(n);
    check("midrst_done_latency", 32'(n), 32'(TICK_DIV + 6));
    check("midrst_lp_first_step", 32'(bus.LP_gain), 32'h7F8);
    check("midrst_steady", 32'(bus.steady), 32'h0);
    $display("reset mid-sweep: sweep_done after %0d cycles", n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
